// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: a prescaler produces quarter-frame ticks, and a 4/5-step
// counter decodes them into registered quarter/half/frame enables and a sticky IRQ.
module apu_frame_sequencer #(
  parameter int unsigned CLKRATE    = 1_790_000,
  parameter int unsigned TICK_HZ    = 240,
  parameter int unsigned PRESCALE_W = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic       cfg_mode,
  input  logic       cfg_irq_inhibit,
  input  logic       irq_ack,
  output logic       quarter_en,
  output logic       half_en,
  output logic       frame_en,
  output logic       irq,
  output logic [2:0] step
);

  localparam int unsigned PRESCALE = CLKRATE / TICK_HZ;
  localparam logic [PRESCALE_W-1:0] RELOAD = PRESCALE_W'(PRESCALE - 1);

  typedef enum logic [2:0] {
    STEP0 = 3'd0,
    STEP1 = 3'd1,
    STEP2 = 3'd2,
    STEP3 = 3'd3,
    STEP4 = 3'd4
  } step_e;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } mode_e;

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  step_e                 step_q, step_d;
  mode_e                 mode_q, mode_d;
  logic                  inhibit_q, inhibit_d;
  logic                  quarter_q, quarter_d;
  logic                  half_q, half_d;
  logic                  frame_q, frame_d;
  logic                  irq_q, irq_d;
  logic                  tick;
  logic                  irq_set;

  assign tick = (presc_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= RELOAD;
      step_q    <= STEP0;
      mode_q    <= MODE_4STEP;
      inhibit_q <= 1'b0;
      quarter_q <= 1'b0;
      half_q    <= 1'b0;
      frame_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      quarter_q <= quarter_d;
      half_q    <= half_d;
      frame_q   <= frame_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    presc_d   = presc_q - PRESCALE_W'(1);
    step_d    = step_q;
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    quarter_d = 1'b0;
    half_d    = 1'b0;
    frame_d   = 1'b0;
    irq_set   = 1'b0;

    if (cfg_we) begin
      // A write restarts the sequence and swallows any coincident tick.
      presc_d   = RELOAD;
      step_d    = STEP0;
      mode_d    = mode_e'(cfg_mode);
      inhibit_d = cfg_irq_inhibit;
      quarter_d = cfg_mode;
      half_d    = cfg_mode;
    end else if (tick) begin
      presc_d = RELOAD;
      case (step_q)
        STEP0: begin
          quarter_d = 1'b1;
          step_d    = STEP1;
        end
        STEP1: begin
          quarter_d = 1'b1;
          half_d    = 1'b1;
          step_d    = STEP2;
        end
        STEP2: begin
          quarter_d = 1'b1;
          step_d    = STEP3;
        end
        STEP3: begin
          if (mode_q == MODE_4STEP) begin
            quarter_d = 1'b1;
            half_d    = 1'b1;
            frame_d   = 1'b1;
            irq_set   = !inhibit_q;
            step_d    = STEP0;
          end else begin
            step_d    = STEP4;
          end
        end
        STEP4: begin
          quarter_d = 1'b1;
          half_d    = 1'b1;
          frame_d   = 1'b1;
          step_d    = STEP0;
        end
        default: step_d = STEP0;
      endcase
    end

    irq_d = irq_q;
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (irq_ack || (cfg_we && cfg_irq_inhibit)) begin
      irq_d = 1'b0;
    end
  end

  assign quarter_en = quarter_q;
  assign half_en    = half_q;
  assign frame_en   = frame_q;
  assign irq        = irq_q;
  assign step       = step_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Scoreboard bench for apu_frame_sequencer: directed scenarios followed by
// randomized traffic, checked against a table-driven model of the step sequence.
module tb_apu_frame_sequencer;

  localparam int P = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic       cfg_mode;
  logic       cfg_irq_inhibit;
  logic       irq_ack;
  logic       quarter_en;
  logic       half_en;
  logic       frame_en;
  logic       irq;
  logic [2:0] step;

  apu_frame_sequencer #(
    .CLKRATE   (2400),
    .TICK_HZ   (240),
    .PRESCALE_W(14)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_mode       (cfg_mode),
    .cfg_irq_inhibit(cfg_irq_inhibit),
    .irq_ack        (irq_ack),
    .quarter_en     (quarter_en),
    .half_en        (half_en),
    .frame_en       (frame_en),
    .irq            (irq),
    .step           (step)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit q;
    bit h;
    bit f;
    bit irq;
    int step;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   total  = 0;
  int   passed = 0;

  // Enables per step: mode 0 has four steps, mode 1 has five.
  string DEC4[4] = '{"Q", "QH", "Q", "QHF"};
  string DEC5[5] = '{"Q", "QH", "Q", "", "QHF"};

  int m_mode, m_inh, m_irq, m_elapsed, m_step;

  function automatic bit has(input string s, input byte c);
    for (int i = 0; i < s.len(); i++) if (s[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Predicts outputs after the coming posedge from the inputs now applied.
  task automatic model_edge();
    exp_t  e;
    string d;
    bit    tick, q, h, f, set;
    q = 0; h = 0; f = 0; set = 0;
    if (rst) begin
      m_mode = 0; m_inh = 0; m_irq = 0; m_elapsed = 0; m_step = 0;
    end else begin
      tick = (m_elapsed % P) == P - 1;
      if (cfg_we) begin
        m_mode = cfg_mode; m_inh = cfg_irq_inhibit;
        m_elapsed = 0; m_step = 0;
        q = cfg_mode; h = cfg_mode;
        if (cfg_irq_inhibit || irq_ack) m_irq = 0;
      end else begin
        if (tick) begin
          d   = (m_mode != 0) ? DEC5[m_step] : DEC4[m_step];
          q   = has(d, "Q");
          h   = has(d, "H");
          f   = has(d, "F");
          set = f && (m_mode == 0) && (m_inh == 0);
          m_step = (m_step + 1) % ((m_mode != 0) ? 5 : 4);
        end
        m_elapsed++;
        if (set) m_irq = 1;
        else if (irq_ack) m_irq = 0;
      end
    end
    e.q = q; e.h = h; e.f = f; e.irq = m_irq[0]; e.step = m_step;
    sb.push_back(e);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else passed++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("quarter_en", 32'(quarter_en), 32'(e.q));
        chk("half_en",    32'(half_en),    32'(e.h));
        chk("frame_en",   32'(frame_en),   32'(e.f));
        chk("irq",        32'(irq),        32'(e.irq));
        chk("step",       32'(step),       32'(e.step));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic write_cfg(input bit mode, input bit inh);
    cfg_we = 1; cfg_mode = mode; cfg_irq_inhibit = inh;
    cyc();
    cfg_we = 0; cfg_mode = 0; cfg_irq_inhibit = 0;
  endtask

  initial begin : stimulus
    exp_t z;
    rst = 1; cfg_we = 0; cfg_mode = 0; cfg_irq_inhibit = 0; irq_ack = 0;
    @(negedge clk);
    repeat (3) cyc();
    rst = 0;
    repeat (40) cyc();

    irq_ack = 1; cyc(); irq_ack = 0;
    for (int n = 0; n < 100 && !((m_elapsed % P) == P - 1 && m_step == 3); n++) cyc();
    irq_ack = 1; cyc(); irq_ack = 0;
    repeat (3) cyc();

    write_cfg(1, 0);
    repeat (60) cyc();

    write_cfg(0, 0);
    repeat (40) cyc();
    write_cfg(0, 1);
    repeat (45) cyc();

    for (int n = 0; n < 20 && (m_elapsed % P) != P - 1; n++) cyc();
    write_cfg(0, 0);
    repeat (12) cyc();

    for (int n = 0; n < 60 && m_step != 2; n++) cyc();
    repeat (3) cyc();
    rst = 1;
    z.q = 0; z.h = 0; z.f = 0; z.irq = 0; z.step = 0;
    sb.push_back(z);
    ->chk_ev;
    #3;
    repeat (2) cyc();
    rst = 0;
    repeat (12) cyc();

    for (int n = 0; n < 2000; n++) begin
      rst             = ($urandom_range(0, 299) == 0);
      cfg_we          = ($urandom_range(0, 59) == 0);
      cfg_mode        = 1'($urandom_range(0, 1));
      cfg_irq_inhibit = ($urandom_range(0, 3) == 0);
      irq_ack         = ($urandom_range(0, 7) == 0);
      cyc();
    end
    rst = 0; cfg_we = 0; irq_ack = 0;
    repeat (2) cyc();
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
